// File: rtl/band_pkg.sv
// Shared types and helpers for the multi-channel guitarist note monitor.
package band_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        NOTE = 2'd2
    } ch_state_t;

    // Channel-index width; a single channel still needs a one-bit index.
    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/note_channel.sv
// One guitarist channel: declares a note once hit has held for HOLD consecutive cycles.
module note_channel
    import band_pkg::*;
#(
    parameter int HOLD = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    output logic note,
    output logic rise
);

    localparam int HW = $clog2(HOLD + 1);

    ch_state_t       state, state_n;
    logic [HW-1:0]   hcnt, hcnt_n;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            hcnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_n = state;
        hcnt_n  = hcnt;
        if (!hit) begin
            state_n = IDLE;
            hcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (HOLD == 1) begin
                        state_n = NOTE;
                    end else begin
                        state_n = ARM;
                        hcnt_n  = HW'(1);
                    end
                end
                ARM: begin
                    hcnt_n = hcnt + 1'b1;
                    if (hcnt + 1'b1 == HW'(HOLD)) state_n = NOTE;
                end
                NOTE:    state_n = NOTE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign note = (state == NOTE);
    // Onset pulse: high in the cycle before note goes 0->1.
    assign rise = (state != NOTE) && (state_n == NOTE);

endmodule

// File: rtl/band_monitor.sv
// Multi-channel registered note detector with saturating onset counter and first-onset capture.
module band_monitor
    import band_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = 2,
    parameter int HOLD = 3,
    parameter int CW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      disconnection,
    input  logic [NCH-1:0]            two_guitars,
    input  logic [NCH*W-1:0]          gossamer,
    input  logic                      clear,
    output logic [NCH-1:0]            note,
    output logic                      nothing_of_note,
    output logic [CW-1:0]             note_count,
    output logic                      first_valid,
    output logic [ch_idx_w(NCH)-1:0]  first_ch
);

    localparam int IW = ch_idx_w(NCH);

    logic [NCH-1:0] hit;
    logic [NCH-1:0] rise;
    logic           onset;
    logic [IW-1:0]  low_ch;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign hit[c] = (|gossamer[c*W +: W]) && (disconnection || two_guitars[c]);

        note_channel #(.HOLD(HOLD)) u_ch (
            .clk   (clk),
            .reset (reset),
            .hit   (hit[c]),
            .note  (note[c]),
            .rise  (rise[c])
        );
    end

    assign onset           = |rise;
    assign nothing_of_note = ~|note;

    // Lowest-index rising channel wins.
    always_comb begin
        low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rise[i]) low_ch = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            note_count  <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else if (onset) begin
            if (note_count != {CW{1'b1}}) note_count <= note_count + 1'b1;
            if (!first_valid) begin
                first_valid <= 1'b1;
                first_ch    <= low_ch;
            end
        end
    end

endmodule

// File: tb/tb_band_monitor.sv
// Directed bench for band_monitor: behavioural run-length model feeds a scoreboard queue.
module tb_band_monitor;
    import band_pkg::*;

    localparam int NCH  = 4;
    localparam int W    = 2;
    localparam int HOLD = 3;
    localparam int CW   = 2;
    localparam int IW   = ch_idx_w(NCH);

    logic              clk = 1'b0;
    logic              reset;
    logic              disconnection;
    logic [NCH-1:0]    two_guitars;
    logic [NCH*W-1:0]  gossamer;
    logic              clear;
    logic [NCH-1:0]    note;
    logic              nothing_of_note;
    logic [CW-1:0]     note_count;
    logic              first_valid;
    logic [IW-1:0]     first_ch;

    band_monitor #(.NCH(NCH), .W(W), .HOLD(HOLD), .CW(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .disconnection   (disconnection),
        .two_guitars     (two_guitars),
        .gossamer        (gossamer),
        .clear           (clear),
        .note            (note),
        .nothing_of_note (nothing_of_note),
        .note_count      (note_count),
        .first_valid     (first_valid),
        .first_ch        (first_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] note;
        logic           non;
        logic [CW-1:0]  cnt;
        logic           fv;
        logic [IW-1:0]  fch;
    } exp_t;

    exp_t          sb[$];
    int            run[NCH];
    logic [CW-1:0] m_cnt;
    logic          m_fv;
    logic [IW-1:0] m_fch;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a channel's note is on once its run of consecutive hits reaches HOLD.
    task automatic model_push();
        exp_t e;
        logic any_on;
        int   low;
        any_on = 1'b0;
        low    = -1;
        if (reset) begin
            for (int c = 0; c < NCH; c++) run[c] = 0;
            m_cnt = '0;
            m_fv  = 1'b0;
            m_fch = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                logic h, was_on;
                h      = (|gossamer[c*W +: W]) && (disconnection || two_guitars[c]);
                was_on = (run[c] >= HOLD);
                run[c] = h ? ((run[c] < HOLD) ? run[c] + 1 : HOLD) : 0;
                if (!was_on && run[c] >= HOLD) begin
                    any_on = 1'b1;
                    if (low < 0) low = c;
                end
            end
            if (clear) begin
                m_cnt = '0;
                m_fv  = 1'b0;
                m_fch = '0;
            end else if (any_on) begin
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                if (!m_fv) begin
                    m_fv  = 1'b1;
                    m_fch = IW'(low);
                end
            end
        end
        for (int c = 0; c < NCH; c++) e.note[c] = (run[c] >= HOLD);
        e.non = ~|e.note;
        e.cnt = m_cnt;
        e.fv  = m_fv;
        e.fch = m_fch;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("note",            32'(note),            32'(e.note));
        check("nothing_of_note", 32'(nothing_of_note), 32'(e.non));
        check("note_count",      32'(note_count),      32'(e.cnt));
        check("first_valid",     32'(first_valid),     32'(e.fv));
        check("first_ch",        32'(first_ch),        32'(e.fch));
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] g, input logic en);
        gossamer[c*W +: W] = g;
        two_guitars[c]     = en;
    endtask

    initial begin
        reset         = 1'b1;
        disconnection = 1'b0;
        two_guitars   = '0;
        gossamer      = '0;
        clear         = 1'b0;
        tick();
        tick();
        check("reset_note", 32'(note), 32'h0);
        check("reset_non",  32'(nothing_of_note), 32'h1);
        reset = 1'b0;
        tick();

        // Ch1 held five cycles: note from the third edge, count 1, first_ch 1.
        set_ch(1, 2'b01, 1'b1);
        tick();
        tick();
        check("ch1_before_hold", 32'(note), 32'h0);
        tick();
        check("ch1_note", 32'(note), 32'h2);
        check("ch1_count", 32'(note_count), 32'h1);
        check("ch1_first", 32'(first_ch), 32'h1);
        tick();
        tick();
        set_ch(1, 2'b00, 1'b0);
        tick();
        check("ch1_drop", 32'(note), 32'h0);

        // Ch3 pattern 1,1,0,1,1,1: dropout restarts the count.
        set_ch(3, 2'b10, 1'b1);
        tick();
        tick();
        set_ch(3, 2'b00, 1'b1);
        tick();
        set_ch(3, 2'b10, 1'b1);
        tick();
        tick();
        check("ch3_restart", 32'(note), 32'h0);
        tick();
        check("ch3_note", 32'(note), 32'h8);
        check("ch3_count", 32'(note_count), 32'h2);

        // Reset while ch3 in NOTE; hit stays asserted.
        reset = 1'b1;
        tick();
        check("rst_note", 32'(note), 32'h0);
        check("rst_non", 32'(nothing_of_note), 32'h1);
        check("rst_count", 32'(note_count), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("ch3_fresh_wait", 32'(note), 32'h0);
        tick();
        check("ch3_after_rst", 32'(note), 32'h8);
        set_ch(3, 2'b00, 1'b0);
        tick();

        // Gated channel: gossamer set, both enables low.
        set_ch(2, 2'b11, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("gated_note", 32'(note), 32'h0);
        check("gated_non", 32'(nothing_of_note), 32'h1);
        disconnection = 1'b1;
        tick();
        tick();
        tick();
        check("disc_note", 32'(note), 32'h4);
        disconnection = 1'b0;
        set_ch(2, 2'b00, 1'b0);
        tick();

        // Clear, then simultaneous ch0/ch2 onsets count once with first_ch=0.
        clear = 1'b1;
        tick();
        check("clear_fv", 32'(first_valid), 32'h0);
        clear = 1'b0;
        set_ch(0, 2'b01, 1'b1);
        set_ch(2, 2'b01, 1'b1);
        tick();
        tick();
        tick();
        check("sim_note", 32'(note), 32'h5);
        check("sim_count", 32'(note_count), 32'h1);
        check("sim_first", 32'(first_ch), 32'h0);
        set_ch(0, 2'b00, 1'b0);
        set_ch(2, 2'b00, 1'b0);
        tick();

        // Four more ch0 onsets: count saturates at 3.
        for (int k = 0; k < 4; k++) begin
            set_ch(0, 2'b11, 1'b1);
            tick();
            tick();
            tick();
            set_ch(0, 2'b00, 1'b0);
            tick();
        end
        check("sat_count", 32'(note_count), 32'h3);

        // Clear coincident with a ch1 onset: clear wins, note still rises.
        set_ch(1, 2'b01, 1'b1);
        tick();
        tick();
        clear = 1'b1;
        tick();
        check("clr_onset_note", 32'(note), 32'h2);
        check("clr_onset_count", 32'(note_count), 32'h0);
        check("clr_onset_fv", 32'(first_valid), 32'h0);
        clear = 1'b0;
        tick();
        check("clr_hold_count", 32'(note_count), 32'h0);
        set_ch(1, 2'b00, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
